// File: rtl/rtc_pkg.sv
// Shared types, digit limits and time validation for the iiitb_rtc_param RTC.
package rtc_pkg;

    localparam logic [3:0] SEC_L_MAX = 4'd9;
    localparam logic [3:0] SEC_M_MAX = 4'd5;
    localparam logic [3:0] MIN_L_MAX = 4'd9;
    localparam logic [3:0] MIN_M_MAX = 4'd5;
    localparam logic [3:0] HR_M_MAX  = 4'd2;
    localparam logic [3:0] HR_L_MAX  = 4'd9;
    localparam int         HR_MAX    = 23;

    typedef struct packed {
        logic [3:0] hrm;
        logic [3:0] hrl;
        logic [3:0] minm;
        logic [3:0] minl;
        logic [3:0] secm;
        logic [3:0] secl;
    } rtc_time_t;

    typedef struct packed {
        logic [3:0] hrm;
        logic [3:0] hrl;
        logic [3:0] minm;
        logic [3:0] minl;
    } rtc_hm_t;

    function automatic logic rtc_valid(input rtc_time_t t);
        int hr;
        hr = 10 * int'(t.hrm) + int'(t.hrl);
        return (t.secl <= SEC_L_MAX) && (t.secm <= SEC_M_MAX) &&
               (t.minl <= MIN_L_MAX) && (t.minm <= MIN_M_MAX) &&
               (t.hrl  <= HR_L_MAX)  && (t.hrm  <= HR_M_MAX)  && (hr <= HR_MAX);
    endfunction

endpackage

// File: rtl/iiitb_rtc_param_if.sv
// Control/display bundle of the RTC; alarm signals exist only with RTC_ALARM_EN.
interface iiitb_rtc_param_if;
    import rtc_pkg::*;

    logic       en;
    logic       load;
    rtc_time_t  ld_time;
    logic       mode_12h;
    logic [3:0] hrm, hrl, minm, minl, secm, secl;
    logic       pm;
    logic       sec_tick;
    logic       load_err;
`ifdef RTC_ALARM_EN
    logic       alm_set;
    rtc_hm_t    alm_time;
    logic       alm_arm;
    logic       alm_ack;
    logic       alarm;
`endif

    modport master (
        output en, load, ld_time, mode_12h,
`ifdef RTC_ALARM_EN
        output alm_set, alm_time, alm_arm, alm_ack,
        input  alarm,
`endif
        input  hrm, hrl, minm, minl, secm, secl, pm, sec_tick, load_err
    );

    modport slave (
        input  en, load, ld_time, mode_12h,
`ifdef RTC_ALARM_EN
        input  alm_set, alm_time, alm_arm, alm_ack,
        output alarm,
`endif
        output hrm, hrl, minm, minl, secm, secl, pm, sec_tick, load_err
    );

endinterface

// File: rtl/rtc_bcd_digit.sv
// Single BCD digit counter 0..MAX with synchronous load and wrap on increment.
module rtc_bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       at_max
);

    assign at_max = (q == MAX);

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst)     q <= '0;
        else if (ld)  q <= ld_val;
        else if (inc) q <= at_max ? 4'd0 : q + 4'd1;
    end

endmodule

// File: rtl/iiitb_rtc_param.sv
// BCD HH:MM:SS real-time clock on a single clock with prescaled seconds enable.
// Optional minute-resolution alarm compiled in with RTC_ALARM_EN.
module iiitb_rtc_param
    import rtc_pkg::*;
#(
    parameter int DIV = 100000000
) (
    input logic              clk,
    input logic              rst,
    iiitb_rtc_param_if.slave bus
);

    localparam int            PW      = $clog2(DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

    logic [PW-1:0] ps_q;
    logic          ld_ok, wrap, tick, alm_bad;
    logic [3:0]    secl_q, secm_q, minl_q, minm_q, hrm_q, hrl_q, hrm_nx, hrl_nx;
    logic          secl_max, secm_max, minl_max, minm_max, sec_wrap, min_wrap;

    assign ld_ok    = bus.load && rtc_valid(bus.ld_time);
    assign wrap     = bus.en && (ps_q == PS_LAST);
    // Any load cycle, accepted or rejected, suppresses the pending second.
    assign tick     = wrap && !bus.load;
    assign sec_wrap = secl_max && secm_max;
    assign min_wrap = minl_max && minm_max;

    always_ff @(posedge clk) begin
        if (!rst)                     ps_q <= '0;
        else if (ld_ok)               ps_q <= '0;
        else if (bus.en && !bus.load) ps_q <= wrap ? '0 : ps_q + 1'b1;
    end

    rtc_bcd_digit #(.MAX(SEC_L_MAX)) u_secl (.clk(clk), .rst(rst), .inc(tick),
        .ld(ld_ok), .ld_val(bus.ld_time.secl), .q(secl_q), .at_max(secl_max));
    rtc_bcd_digit #(.MAX(SEC_M_MAX)) u_secm (.clk(clk), .rst(rst), .inc(tick && secl_max),
        .ld(ld_ok), .ld_val(bus.ld_time.secm), .q(secm_q), .at_max(secm_max));
    rtc_bcd_digit #(.MAX(MIN_L_MAX)) u_minl (.clk(clk), .rst(rst), .inc(tick && sec_wrap),
        .ld(ld_ok), .ld_val(bus.ld_time.minl), .q(minl_q), .at_max(minl_max));
    rtc_bcd_digit #(.MAX(MIN_M_MAX)) u_minm (.clk(clk), .rst(rst),
        .inc(tick && sec_wrap && minl_max),
        .ld(ld_ok), .ld_val(bus.ld_time.minm), .q(minm_q), .at_max(minm_max));

    // Hour pair advances as one unit: 09->10, 19->20, 23->00.
    // NOTE: defaults first so every path assigns every output (no latch).
    always_comb begin
        hrm_nx = hrm_q;
        hrl_nx = hrl_q + 4'd1;
        if (hrm_q == HR_M_MAX && hrl_q == 4'd3) begin
            hrm_nx = 4'd0;
            hrl_nx = 4'd0;
        end else if (hrl_q == HR_L_MAX) begin
            hrm_nx = hrm_q + 4'd1;
            hrl_nx = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hrm_q <= '0;
            hrl_q <= '0;
        end else if (ld_ok) begin
            hrm_q <= bus.ld_time.hrm;
            hrl_q <= bus.ld_time.hrl;
        end else if (tick && sec_wrap && min_wrap) begin
            hrm_q <= hrm_nx;
            hrl_q <= hrl_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.sec_tick <= 1'b0;
            bus.load_err <= 1'b0;
        end else begin
            bus.sec_tick <= tick;
            bus.load_err <= (bus.load && !ld_ok) || alm_bad;
        end
    end

    assign bus.pm   = (hrm_q == 4'd2) || (hrm_q == 4'd1 && hrl_q >= 4'd2);
    assign bus.minm = minm_q;
    assign bus.minl = minl_q;
    assign bus.secm = secm_q;
    assign bus.secl = secl_q;

    always_comb begin
        bus.hrm = hrm_q;
        bus.hrl = hrl_q;
        if (bus.mode_12h) begin
            if (hrm_q == 4'd0 && hrl_q == 4'd0) begin
                bus.hrm = 4'd1;
                bus.hrl = 4'd2;
            end else if (hrm_q == 4'd1 && hrl_q >= 4'd3) begin
                bus.hrm = 4'd0;
                bus.hrl = hrl_q - 4'd2;
            end else if (hrm_q == 4'd2 && hrl_q <= 4'd1) begin
                bus.hrm = 4'd0;
                bus.hrl = hrl_q + 4'd8;
            end else if (hrm_q == 4'd2) begin
                bus.hrm = 4'd1;
                bus.hrl = hrl_q - 4'd2;
            end
        end
    end

`ifdef RTC_ALARM_EN
    rtc_hm_t alm_q, next_hm;
    logic    alm_ok, alm_match, alarm_q;

    assign alm_ok  = bus.alm_set && rtc_valid(rtc_time_t'({bus.alm_time, 8'h00}));
    assign alm_bad = bus.alm_set && !alm_ok;

    // HH:MM the clock will show after a seconds rollover this cycle.
    always_comb begin
        next_hm.minl = minl_max ? 4'd0 : minl_q + 4'd1;
        next_hm.minm = minl_max ? (minm_max ? 4'd0 : minm_q + 4'd1) : minm_q;
        next_hm.hrm  = min_wrap ? hrm_nx : hrm_q;
        next_hm.hrl  = min_wrap ? hrl_nx : hrl_q;
    end

    assign alm_match = tick && sec_wrap && bus.alm_arm && (next_hm == alm_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            alm_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            if (alm_ok)           alm_q   <= bus.alm_time;
            if (alm_match)        alarm_q <= 1'b1;
            else if (bus.alm_ack) alarm_q <= 1'b0;
        end
    end

    assign bus.alarm = alarm_q;
`else
    assign alm_bad = 1'b0;
`endif

endmodule

// File: tb/tb_iiitb_rtc_param.sv
// Directed self-checking bench for iiitb_rtc_param with DIV = 4.
module tb_iiitb_rtc_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    iiitb_rtc_param_if bus ();

    iiitb_rtc_param #(.DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [23:0] shown;
    assign shown = {bus.hrm, bus.hrl, bus.minm, bus.minl, bus.secm, bus.secl};

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [23:0] t);
        bus.ld_time = t;
        bus.load    = 1'b1;
        step(1);
        bus.load    = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        step(3);
        n_cmp++; if (shown !== 24'h000000) begin n_bad++; $display("FAIL reset_time: got %06h want 000000", shown); end
        n_cmp++; if (bus.sec_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %0b want 0", bus.sec_tick); end
        n_cmp++; if (bus.load_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", bus.load_err); end
        bus.mode_12h = 1'b1;
        #1;
        n_cmp++; if (shown !== 24'h120000) begin n_bad++; $display("FAIL reset_12h: got %06h want 120000", shown); end
        n_cmp++; if (bus.pm !== 1'b0) begin n_bad++; $display("FAIL reset_pm: got %0b want 0", bus.pm); end
        bus.mode_12h = 1'b0;
        rst = 1'b1;
        step(1);
    endtask

    task automatic test_rollover;
        logic exp_tick;
        do_load(24'h235958);
        bus.en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            exp_tick = (i % 4 == 0);
            n_cmp++; if (bus.sec_tick !== exp_tick) begin n_bad++; $display("FAIL roll_tick%0d: got %0b want %0b", i, bus.sec_tick, exp_tick); end
            if (i == 3) begin
                n_cmp++; if (shown !== 24'h235958) begin n_bad++; $display("FAIL roll_hold: got %06h want 235958", shown); end
            end
            if (i == 4) begin
                n_cmp++; if (shown !== 24'h235959) begin n_bad++; $display("FAIL roll_59: got %06h want 235959", shown); end
            end
            if (i == 8) begin
                n_cmp++; if (shown !== 24'h000000) begin n_bad++; $display("FAIL roll_wrap: got %06h want 000000", shown); end
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_invalid_load;
        do_load(24'h240000);
        n_cmp++; if (bus.load_err !== 1'b1) begin n_bad++; $display("FAIL inv_hr_err: got %0b want 1", bus.load_err); end
        n_cmp++; if (shown !== 24'h000000) begin n_bad++; $display("FAIL inv_hr_time: got %06h want 000000", shown); end
        step(1);
        n_cmp++; if (bus.load_err !== 1'b0) begin n_bad++; $display("FAIL inv_err_pulse: got %0b want 0", bus.load_err); end
        do_load(24'h126000);
        n_cmp++; if (bus.load_err !== 1'b1) begin n_bad++; $display("FAIL inv_min_err: got %0b want 1", bus.load_err); end
        n_cmp++; if (shown !== 24'h000000) begin n_bad++; $display("FAIL inv_min_time: got %06h want 000000", shown); end
        do_load(24'h195959);
        n_cmp++; if (bus.load_err !== 1'b0) begin n_bad++; $display("FAIL ok_load_err: got %0b want 0", bus.load_err); end
        n_cmp++; if (shown !== 24'h195959) begin n_bad++; $display("FAIL ok_load_time: got %06h want 195959", shown); end
        bus.en = 1'b1;
        step(3);
        n_cmp++; if (bus.sec_tick !== 1'b0) begin n_bad++; $display("FAIL ok_early_tick: got %0b want 0", bus.sec_tick); end
        step(1);
        n_cmp++; if (bus.sec_tick !== 1'b1) begin n_bad++; $display("FAIL ok_tick: got %0b want 1", bus.sec_tick); end
        n_cmp++; if (shown !== 24'h200000) begin n_bad++; $display("FAIL hr_19_20: got %06h want 200000", shown); end
        bus.en = 1'b0;
    endtask

    task automatic test_12h;
        logic [23:0] ld_tab  [0:5] = '{24'h130500, 24'h003000, 24'h120000, 24'h115959, 24'h210000, 24'h230000};
        logic [23:0] exp_tab [0:5] = '{24'h010500, 24'h123000, 24'h120000, 24'h115959, 24'h090000, 24'h110000};
        logic        pm_tab  [0:5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bus.mode_12h = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_load(ld_tab[i]);
            n_cmp++; if (shown !== exp_tab[i]) begin n_bad++; $display("FAIL h12_disp%0d: got %06h want %06h", i, shown, exp_tab[i]); end
            n_cmp++; if (bus.pm !== pm_tab[i]) begin n_bad++; $display("FAIL h12_pm%0d: got %0b want %0b", i, bus.pm, pm_tab[i]); end
        end
        bus.mode_12h = 1'b0;
        #1;
        n_cmp++; if (shown !== 24'h230000) begin n_bad++; $display("FAIL h24_back: got %06h want 230000", shown); end
        n_cmp++; if (bus.pm !== 1'b1) begin n_bad++; $display("FAIL h24_pm: got %0b want 1", bus.pm); end
    endtask

    task automatic test_load_vs_wrap;
        do_load(24'h090000);
        bus.en = 1'b1;
        step(3);
        n_cmp++; if (bus.sec_tick !== 1'b0) begin n_bad++; $display("FAIL lw_pre: got %0b want 0", bus.sec_tick); end
        bus.ld_time = 24'h100000;
        bus.load    = 1'b1;
        step(1);
        bus.load    = 1'b0;
        n_cmp++; if (bus.sec_tick !== 1'b0) begin n_bad++; $display("FAIL lw_tick: got %0b want 0", bus.sec_tick); end
        n_cmp++; if (shown !== 24'h100000) begin n_bad++; $display("FAIL lw_time: got %06h want 100000", shown); end
        step(3);
        n_cmp++; if (bus.sec_tick !== 1'b0) begin n_bad++; $display("FAIL lw_early: got %0b want 0", bus.sec_tick); end
        step(1);
        n_cmp++; if (bus.sec_tick !== 1'b1) begin n_bad++; $display("FAIL lw_next: got %0b want 1", bus.sec_tick); end
        n_cmp++; if (shown !== 24'h100001) begin n_bad++; $display("FAIL lw_next_time: got %06h want 100001", shown); end
        bus.en = 1'b0;
    endtask

    task automatic test_en_hold;
        bus.en = 1'b1;
        step(2);
        bus.en = 1'b0;
        step(5);
        n_cmp++; if (bus.sec_tick !== 1'b0 || shown !== 24'h100001) begin n_bad++; $display("FAIL hold_frozen: got %0b/%06h want 0/100001", bus.sec_tick, shown); end
        bus.en = 1'b1;
        step(1);
        n_cmp++; if (bus.sec_tick !== 1'b0) begin n_bad++; $display("FAIL hold_resume: got %0b want 0", bus.sec_tick); end
        step(1);
        n_cmp++; if (bus.sec_tick !== 1'b1) begin n_bad++; $display("FAIL hold_tick: got %0b want 1", bus.sec_tick); end
        n_cmp++; if (shown !== 24'h100002) begin n_bad++; $display("FAIL hold_time: got %06h want 100002", shown); end
        bus.en = 1'b0;
    endtask

`ifdef RTC_ALARM_EN
    task automatic test_alarm;
        bus.alm_arm  = 1'b1;
        bus.alm_time = 16'h0700;
        bus.alm_set  = 1'b1;
        step(1);
        bus.alm_set  = 1'b0;
        n_cmp++; if (bus.load_err !== 1'b0) begin n_bad++; $display("FAIL alm_set_err: got %0b want 0", bus.load_err); end
        do_load(24'h065959);
        bus.en = 1'b1;
        step(3);
        n_cmp++; if (bus.alarm !== 1'b0) begin n_bad++; $display("FAIL alm_early: got %0b want 0", bus.alarm); end
        step(1);
        bus.en = 1'b0;
        n_cmp++; if (shown !== 24'h070000) begin n_bad++; $display("FAIL alm_time: got %06h want 070000", shown); end
        n_cmp++; if (bus.alarm !== 1'b1) begin n_bad++; $display("FAIL alm_fire: got %0b want 1", bus.alarm); end
        step(2);
        n_cmp++; if (bus.alarm !== 1'b1) begin n_bad++; $display("FAIL alm_sticky: got %0b want 1", bus.alarm); end
        bus.alm_ack = 1'b1;
        step(1);
        bus.alm_ack = 1'b0;
        n_cmp++; if (bus.alarm !== 1'b0) begin n_bad++; $display("FAIL alm_ack: got %0b want 0", bus.alarm); end
        bus.alm_time = 16'h2400;
        bus.alm_set  = 1'b1;
        step(1);
        bus.alm_set  = 1'b0;
        n_cmp++; if (bus.load_err !== 1'b1) begin n_bad++; $display("FAIL alm_bad_err: got %0b want 1", bus.load_err); end
        do_load(24'h065959);
        bus.en = 1'b1;
        step(3);
        bus.alm_ack = 1'b1;
        step(1);
        bus.alm_ack = 1'b0;
        bus.en      = 1'b0;
        n_cmp++; if (bus.alarm !== 1'b1) begin n_bad++; $display("FAIL alm_set_wins: got %0b want 1", bus.alarm); end
        bus.alm_ack = 1'b1;
        step(1);
        bus.alm_ack = 1'b0;
        bus.alm_arm = 1'b0;
        do_load(24'h065959);
        bus.en = 1'b1;
        step(4);
        bus.en = 1'b0;
        n_cmp++; if (shown !== 24'h070000 || bus.alarm !== 1'b0) begin n_bad++; $display("FAIL alm_disarmed: got %06h/%0b want 070000/0", shown, bus.alarm); end
    endtask
`endif

    task automatic test_reset_mid;
        do_load(24'h123456);
        bus.en      = 1'b1;
        bus.ld_time = 24'h120000;
        bus.load    = 1'b1;
        rst         = 1'b0;
        step(1);
        bus.load = 1'b0;
        rst      = 1'b1;
        n_cmp++; if (shown !== 24'h000000) begin n_bad++; $display("FAIL rmid_time: got %06h want 000000", shown); end
        n_cmp++; if (bus.sec_tick !== 1'b0) begin n_bad++; $display("FAIL rmid_tick: got %0b want 0", bus.sec_tick); end
        step(3);
        n_cmp++; if (bus.sec_tick !== 1'b0) begin n_bad++; $display("FAIL rmid_ps_early: got %0b want 0", bus.sec_tick); end
        step(1);
        n_cmp++; if (bus.sec_tick !== 1'b1 || shown !== 24'h000001) begin n_bad++; $display("FAIL rmid_ps: got %0b/%06h want 1/000001", bus.sec_tick, shown); end
        bus.en = 1'b0;
    endtask

    initial begin
        bus.en       = 1'b0;
        bus.load     = 1'b0;
        bus.ld_time  = '0;
        bus.mode_12h = 1'b0;
`ifdef RTC_ALARM_EN
        bus.alm_set  = 1'b0;
        bus.alm_time = '0;
        bus.alm_arm  = 1'b0;
        bus.alm_ack  = 1'b0;
`endif
        test_reset();
        test_rollover();
        test_invalid_load();
        test_12h();
        test_load_vs_wrap();
        test_en_hold();
`ifdef RTC_ALARM_EN
        test_alarm();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
